// File: rtl/frame_pixel_streamer.sv
// rtl/frame_pixel_streamer.sv - raster-order pixel streamer with ready/valid output; FRAME_REPEAT_EN enables continuous frames
module frame_pixel_streamer #(
  parameter int frame_width  = 640,
  parameter int frame_height = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] mem_x,
  output logic [31:0] mem_y,
  input  logic [1:0]  mem_pix,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_pix,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam logic [31:0] x_last = 32'(frame_width - 1);
  localparam logic [31:0] y_last = 32'(frame_height - 1);

  state_t state, state_nx;
  logic   load, accept, at_x_end, at_last;

  assign accept   = out_valid & out_ready;
  assign load     = (state == STREAM) & (~out_valid | out_ready);
  assign at_x_end = (mem_x == x_last);
  assign at_last  = at_x_end & (mem_y == y_last);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = STREAM;
      STREAM: if (load && at_last) state_nx = FLUSH;
      FLUSH: begin
        if (accept) begin
`ifdef FRAME_REPEAT_EN
          state_nx = STREAM;
`else
          state_nx = IDLE;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_x     <= 32'd0;
      mem_y     <= 32'd0;
      out_valid <= 1'b0;
      out_pix   <= 2'd0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (load) begin
        out_pix   <= mem_pix;
        out_valid <= 1'b1;
        out_sof   <= (mem_x == 32'd0) && (mem_y == 32'd0);
        out_eol   <= at_x_end;
        out_eof   <= at_last;
        // the address parks at (0,0) once the last pixel is loaded
        if (at_last) begin
          mem_x <= 32'd0;
          mem_y <= 32'd0;
        end else if (at_x_end) begin
          mem_x <= 32'd0;
          mem_y <= mem_y + 32'd1;
        end else begin
          mem_x <= mem_x + 32'd1;
        end
      end else if (accept) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eol   <= 1'b0;
        out_eof   <= 1'b0;
        if (state == FLUSH) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb/tb_frame_pixel_streamer.sv - scoreboard bench for frame_pixel_streamer at 4x3
module tb_frame_pixel_streamer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [31:0] mem_x, mem_y;
  logic [1:0]  mem_pix;
  logic        out_valid, out_sof, out_eol, out_eof, busy, done;
  logic [1:0]  out_pix;

  logic [1:0]  pixmem [0:N-1];
  logic [4:0]  exp_q [$];
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  assign mem_pix = (mem_x < W && mem_y < H) ? pixmem[mem_y * W + mem_x] : 2'd0;

  frame_pixel_streamer #(.frame_width(W), .frame_height(H)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_x(mem_x), .mem_y(mem_y),
    .mem_pix(mem_pix), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .done(done)
  );

  task automatic fill_and_push();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      pixmem[i] = 2'($urandom_range(0, 3));
      exp_q.push_back({pixmem[i], i == 0, (i % W) == W - 1, i == N - 1});
    end
  endtask

  task automatic test_reset();
    logic [71:0] got;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    got = {mem_x, mem_y, out_valid, out_pix, out_sof, out_eol, out_eof, busy, done};
    if (got !== 72'd0) $display("FAIL reset_state got=%h want=0", got); else passed++;
    total++;
    rst = 1'b0;
    @(negedge clk);
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset_idle busy=%b valid=%b want 0/0", busy, out_valid);
    else passed++;
    total++;
  endtask

  // Streams one frame against the scoreboard; optional stalls, start re-pulse and mid-frame reset.
  task automatic run_frame(input string tag, input int stall_a, input int stall_b,
                           input int restart_at, input int rst_at);
    int  acc = 0, dones = 0, first_valid = -1, last_valid = -1, valid_cycles = 0;
    int  eof_cyc = -10, sa = 3, sb = 3, idx;
    bit  restarted = 0;
    fill_and_push();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (mem_x >= W || mem_y >= H) begin
        $display("FAIL %s addr_range x=%0d y=%0d", tag, mem_x, mem_y); total++;
      end
      if (done) begin
        dones++;
        if (cyc !== eof_cyc + 1 || acc !== N)
          $display("FAIL %s done_timing cyc=%0d acc=%0d want cyc=%0d acc=%0d", tag, cyc, acc, eof_cyc + 1, N);
        else passed++;
        total++;
      end
      if (out_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra_pixel got=%b%b%b%b", tag, out_pix, out_sof, out_eol, out_eof); total++;
        end else begin
          if ({out_pix, out_sof, out_eol, out_eof} !== exp_q[0])
            $display("FAIL %s pixel%0d got=%b want=%b", tag, N - exp_q.size(),
                     {out_pix, out_sof, out_eol, out_eof}, exp_q[0]);
          else passed++;
          total++;
        end
      end else if ({out_sof, out_eol, out_eof} !== 3'b000) begin
        $display("FAIL %s markers_when_invalid got=%b want=000", tag, {out_sof, out_eol, out_eof}); total++;
      end
      idx = N - exp_q.size();
      if (rst_at >= 0 && out_valid && idx == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if ({mem_x, mem_y, out_valid, out_pix, out_sof, out_eol, out_eof, busy, done} !== 72'd0)
          $display("FAIL %s midframe_reset got valid=%b pix=%0d busy=%b done=%b x=%0d y=%0d want all 0",
                   tag, out_valid, out_pix, busy, done, mem_x, mem_y);
        else passed++;
        total++;
        return;
      end
      out_ready = 1'b1;
      if (out_valid && idx == stall_a && sa > 0) begin out_ready = 1'b0; sa--; end
      if (out_valid && idx == stall_b && sb > 0) begin out_ready = 1'b0; sb--; end
      start = 1'b0;
      if (restart_at >= 0 && out_valid && idx == restart_at && !restarted) begin
        start = 1'b1; restarted = 1;
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        acc++;
        if (idx == N - 1) eof_cyc = cyc;
      end
      if (dones > 0 && cyc > eof_cyc + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (acc !== N || dones !== 1) $display("FAIL %s totals acc=%0d done=%0d want %0d/1", tag, acc, dones, N);
    else passed++;
    total++;
    if (first_valid !== 2) $display("FAIL %s latency got=%0d want=2", tag, first_valid); else passed++;
    total++;
    if (valid_cycles !== N + (stall_a >= 0 ? 3 : 0) + (stall_b >= 0 ? 3 : 0) ||
        last_valid - first_valid + 1 !== valid_cycles)
      $display("FAIL %s valid_run got=%0d span=%0d", tag, valid_cycles, last_valid - first_valid + 1);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL %s busy_after got=%b want=0", tag, busy); else passed++;
    total++;
  endtask

  task automatic test_basic();           run_frame("basic",   -1, -1, -1, -1); endtask
  task automatic test_stall();           run_frame("stall",    2,  5, -1, -1); endtask
  task automatic test_start_ignored();   run_frame("restart", -1, -1,  6, -1); endtask
  task automatic test_reset_midframe();
    run_frame("midrst", -1, -1, -1, 7);
    run_frame("after_rst", -1, -1, -1, -1);
  endtask

  task automatic test_idle_after_done();
    int bad = 0;
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    if (bad !== 0) $display("FAIL idle_after_done bad_cycles=%0d want=0", bad); else passed++;
    total++;
  endtask

  task automatic test_repeat();
    int ph, dones = 0;
    fill_and_push();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      ph = (cyc >= 2) ? (cyc - 2) % (N + 1) : N;
      if (out_valid !== (cyc >= 2 && ph < N) || done !== (cyc > 2 && ph == N))
        $display("FAIL repeat_timing cyc=%0d valid=%b done=%b", cyc, out_valid, done);
      else passed++;
      total++;
      if (done) dones++;
      if (out_valid && ph < N) begin
        if ({out_pix, out_sof, out_eol, out_eof} !== exp_q[ph])
          $display("FAIL repeat_pixel%0d got=%b want=%b", ph, {out_pix, out_sof, out_eol, out_eof}, exp_q[ph]);
        else passed++;
        total++;
      end
      @(negedge clk);
    end
    if (dones !== 4) $display("FAIL repeat_done_count got=%0d want=4", dones); else passed++;
    total++;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef FRAME_REPEAT_EN
    test_repeat();
`else
    test_basic();
    test_idle_after_done();
    test_stall();
    test_start_ignored();
    test_reset_midframe();
    test_idle_after_done();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/frame_pixel_streamer.md
FRAME_PIXEL_STREAMER -- requirements
Module: frame_pixel_streamer

Interface
REQ-001 Parameter frame_width, default 640, meaning pixels per row (columns); legal range 2..65535.
REQ-002 Parameter frame_height, default 480, meaning rows per frame; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin one frame; sampled only in IDLE.
REQ-006 mem_x  output  32  column address driven to the pixel memory's width port.
REQ-007 mem_y  output  32  row address driven to the pixel memory's height port.
REQ-008 mem_pix  input  2  pixel value returned combinationally, same cycle, for (mem_y, mem_x).
REQ-009 out_valid  output  1  out_pix and markers hold a valid pixel.
REQ-010 out_ready  input  1  downstream accepts the pixel when high together with out_valid.
REQ-011 out_pix  output  2  registered pixel value.
REQ-012 out_sof  output  1  marks pixel (0,0); qualified by out_valid.
REQ-013 out_eol  output  1  marks x = frame_width-1; qualified by out_valid.
REQ-014 out_eof  output  1  marks the last pixel of the frame; qualified by out_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-017 States: IDLE, STREAM, FLUSH; no other states are reachable.
REQ-018 IDLE: mem_x = mem_y = 0, out_valid = 0; start = 1 moves to STREAM next cycle.
REQ-019 Load condition, STREAM only: out_valid = 0 or (out_valid and out_ready).
REQ-020 On a load: out_pix <= mem_pix, out_valid <= 1, out_sof/out_eol/out_eof <= markers computed from the current mem_x/mem_y, then the address advances.
REQ-021 Address advance: mem_x increments; at frame_width-1 it wraps to 0 and mem_y increments; mem_x and mem_y never exceed frame_width-1 and frame_height-1.
REQ-022 Loading the pixel at (frame_width-1, frame_height-1) moves to FLUSH and returns the address to (0,0).
REQ-023 Output accepted with no new load: out_valid <= 0; held pixel and markers stay stable while out_valid = 1 and out_ready = 0.
REQ-024 Latency: first out_valid rises 2 cycles after the start cycle; with out_ready held high, one pixel per cycle, frame_width*frame_height consecutive valid cycles.
REQ-025 FLUSH: when the eof pixel is accepted, out_valid <= 0, done pulses for exactly one cycle, state moves to IDLE (see REQ-030).
REQ-026 start asserted while busy = 1 is ignored and does not restart or corrupt the frame.
REQ-027 Markers are 0 whenever out_valid = 0.

Reset
REQ-028 rst = 1 on a clock edge forces IDLE, mem_x = 0, mem_y = 0, out_valid = 0, out_pix = 0, out_sof = out_eol = out_eof = 0, busy = 0, done = 0.
REQ-029 rst mid-frame abandons the frame with no done pulse; a later start streams a complete frame from (0,0).

Configuration
REQ-030 Macro FRAME_REPEAT_EN: when defined, the eof acceptance moves FLUSH directly to STREAM, done still pulses, and the next frame's sof pixel is loaded on the first STREAM cycle; streaming continues until rst. When not defined, FLUSH returns to IDLE and a new start is required.

Verification
REQ-031 frame_width=4, frame_height=3, out_ready=1, start pulse -> 12 consecutive valid pixels matching memory in raster order; sof on pixel 0, eol on pixels 3/7/11, eof on pixel 11, done one cycle later.
REQ-032 Same config, out_ready low on pixels 2 and 5 for 3 cycles each -> out_pix and markers stable while stalled, no pixel lost or duplicated, 12 total accepted.
REQ-033 start re-pulsed at pixel 6 -> ignored; frame completes with exactly 12 pixels and one done pulse.
REQ-034 rst asserted at pixel 7 -> next cycle all outputs 0, no done; subsequent start yields a full 12-pixel frame beginning at (0,0) with sof.
REQ-035 FRAME_REPEAT_EN defined, out_ready=1 -> done pulses every 12 accepted pixels, sof follows eof, and no gap cycle occurs between frames apart from the single flush transition.
REQ-036 Without FRAME_REPEAT_EN, after done -> busy = 0, out_valid stays 0 for 20 cycles with no start.
